// File: rtl/uart_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing one UART byte transmitter between two sources.
// Optional stall timeout is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_frame_arbiter #(
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic       tx_idle,
  output logic [7:0] dataout,
  output logic       wrsig,
  output logic [1:0] grant,
  output logic       busy,
  output logic       abort
);

  localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;

  if (GAP_CYCLES < 1) begin : g_gap_chk
    $error("GAP_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_to_chk
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [1:0]      grant_q, grant_d;
  logic            rr_q, rr_d;
  logic            last_q, last_d;
  logic [7:0]      data_q, data_d;
  logic            wrsig_q, wrsig_d;
  logic            abort_q, abort_d;
  logic            owner;
  logic            owner_valid;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] to_q, to_d;

  always_ff @(posedge clk) begin
    if (rst) to_q <= '0;
    else     to_q <= to_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      grant_q <= '0;
      rr_q    <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      wrsig_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      last_q  <= last_d;
      data_q  <= data_d;
      wrsig_q <= wrsig_d;
      abort_q <= abort_d;
    end
  end

  assign owner       = grant_q[1];
  assign owner_valid = grant_q[1] ? req1_valid : req0_valid;

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    last_d     = last_q;
    data_d     = data_q;
    wrsig_d    = 1'b0;
    abort_d    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    to_d       = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0_valid && req1_valid) grant_d = rr_q ? 2'b10 : 2'b01;
        else if (req0_valid)          grant_d = 2'b01;
        else if (req1_valid)          grant_d = 2'b10;
        if (req0_valid || req1_valid) begin
          state_d = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      WAIT: begin
        req0_ready = grant_q[0] & req0_valid & tx_idle;
        req1_ready = grant_q[1] & req1_valid & tx_idle;
        if (req0_ready || req1_ready) begin
          data_d  = req1_ready ? req1_data : req0_data;
          last_d  = req1_ready ? req1_last : req0_last;
          gap_d   = GW'(GAP_CYCLES - 1);
          wrsig_d = 1'b1;
          state_d = GAP;
`ifdef UART_ARB_TIMEOUT_EN
          to_d    = '0;
        end else if (tx_idle && !owner_valid) begin
          // only source silence counts; a busy UART is not the source's fault
          if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            abort_d = 1'b1;
            grant_d = '0;
            rr_d    = ~owner;
            to_d    = '0;
            state_d = IDLE;
          end else begin
            to_d = to_q + TW'(1);
          end
`endif
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          if (last_q) begin
            grant_d = '0;
            rr_d    = ~owner;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
            to_d    = '0;
`endif
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dataout = data_q;
  assign wrsig   = wrsig_q;
  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign abort   = abort_q;

endmodule
